mem_arbiter: RTL and testbench

- Merges the core's instruction-side and data-side memory request interfaces onto one shared external memory port. Intended for single-ported SoC memory behind the core's imemory/dmemory outputs.
- Buffers one request per requester and arbitrates between them, round-robin or data-first.
- Keeps exactly one transaction outstanding on the shared port and routes each response back to the requester that issued it.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction- and data-side requests onto one shared memory port
// Ports: clock, reset (async, active-high); i_* and d_* carry each requester's
// request (valid/instr/addr/wdata/wstrb) and its response (rdata/ready);
// mem_* is the shared single-outstanding memory port; grant_d is high while a
// data-side transaction is in flight; protocol_error latches any dropped request.
module mem_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    input  logic        i_instr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_valid,
    input  logic        d_instr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        grant_d,
    output logic        protocol_error
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0]  state;
    logic        i_full, d_full, last_d;
    logic [68:0] i_slot, d_slot, i_req, d_req;
    logic        done, i_free, d_free, i_acc, d_acc, i_cand, d_cand, grant, win_d;

    // a response is only taken once the issue cycle is over
    assign done    = (state != IDLE) && mem_ready && !mem_valid;
    assign i_ready = done && state == BUSY_I;
    assign d_ready = done && state == BUSY_D;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign grant_d = state == BUSY_D;

    // a requester may refill in the very cycle its own response returns
    assign i_free = (!i_full && state != BUSY_I) || i_ready;
    assign d_free = (!d_full && state != BUSY_D) || d_ready;
    assign i_acc  = i_valid && i_free;
    assign d_acc  = d_valid && d_free;
    assign i_cand = i_full || i_acc;
    assign d_cand = d_full || d_acc;
    assign grant  = (state == IDLE || done) && (i_cand || d_cand);
    // last_d low means the instruction side was granted last, so data takes the tie
    assign win_d  = d_cand && (!i_cand || PRIORITY_MODE != 0 || !last_d);
    assign i_req  = i_full ? i_slot : {i_instr, i_addr, i_wdata, i_wstrb};
    assign d_req  = d_full ? d_slot : {d_instr, d_addr, d_wdata, d_wstrb};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            i_full         <= 1'b0;
            d_full         <= 1'b0;
            i_slot         <= '0;
            d_slot         <= '0;
            last_d         <= 1'b0;
            mem_valid      <= 1'b0;
            mem_instr      <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
            protocol_error <= 1'b0;
        end else begin
            mem_valid <= grant;
            if ((i_valid && !i_free) || (d_valid && !d_free))
                protocol_error <= 1'b1;
            if (grant) begin
                {mem_instr, mem_addr, mem_wdata, mem_wstrb} <= win_d ? d_req : i_req;
                state  <= win_d ? BUSY_D : BUSY_I;
                last_d <= win_d;
            end else if (done) begin
                state <= IDLE;
            end
            // a winner taken straight from its inputs never occupies its slot
            if (grant && !win_d) begin
                i_full <= 1'b0;
            end else if (i_acc) begin
                i_full <= 1'b1;
                i_slot <= {i_instr, i_addr, i_wdata, i_wstrb};
            end
            if (grant && win_d) begin
                d_full <= 1'b0;
            end else if (d_acc) begin
                d_full <= 1'b1;
                d_slot <= {d_instr, d_addr, d_wdata, d_wstrb};
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a request-level reference model
module tb_mem_arbiter;
    localparam int PM = 0;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        i_valid = 0, i_instr = 0, d_valid = 0, d_instr = 0, mem_ready = 0;
    logic [31:0] i_addr = 0, i_wdata = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  i_wstrb = 0, d_wstrb = 0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, mem_valid, mem_instr, grant_d, protocol_error;
    logic [3:0]  mem_wstrb;

    logic        p_iv = 0, p_dv = 0, p_mr = 0;
    logic [31:0] p_i_rdata, p_d_rdata, p_mem_addr, p_mem_wdata;
    logic        p_i_ready, p_d_ready, p_mem_valid, p_mem_instr, p_grant_d, p_protocol_error;
    logic [3:0]  p_mem_wstrb;

    int n_cmp = 0;
    int n_bad = 0;
    int mv_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.PRIORITY_MODE(PM)) dut (
        .clock(clk), .reset(rst),
        .i_valid(i_valid), .i_instr(i_instr), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_valid(d_valid), .d_instr(d_instr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_d(grant_d), .protocol_error(protocol_error)
    );

    mem_arbiter #(.PRIORITY_MODE(1)) dut_p (
        .clock(clk), .reset(rst),
        .i_valid(p_iv), .i_instr(i_instr), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_rdata(p_i_rdata), .i_ready(p_i_ready),
        .d_valid(p_dv), .d_instr(d_instr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(p_d_rdata), .d_ready(p_d_ready),
        .mem_valid(p_mem_valid), .mem_instr(p_mem_instr), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_wstrb(p_mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(p_mr),
        .grant_d(p_grant_d), .protocol_error(p_protocol_error)
    );

    // reference model: side 0 = instruction, side 1 = data; owner -1 = nothing outstanding
    req_t m_pend[2] = '{default: '0};
    bit   m_has[2]  = '{0, 0};
    int   m_owner   = -1;
    bit   m_issue   = 0;
    req_t m_out     = '0;
    bit   m_lastd   = 0;
    bit   m_err     = 0;
    req_t n_pend[2], inreq[2];
    bit   n_has[2], take[2], want[2], vin[2];
    int   n_owner;
    bit   n_issue, n_lastd, n_err, resp, go_d;
    req_t n_out;

    always_comb begin
        inreq[0] = {i_instr, i_addr, i_wdata, i_wstrb};
        inreq[1] = {d_instr, d_addr, d_wdata, d_wstrb};
        vin[0]   = i_valid;
        vin[1]   = d_valid;
        take     = '{0, 0};
        want     = '{0, 0};
        n_pend   = m_pend;
        n_has    = m_has;
        n_owner  = m_owner;
        n_out    = m_out;
        n_lastd  = m_lastd;
        n_err    = m_err;
        n_issue  = 0;
        resp     = m_owner >= 0 && mem_ready && !m_issue;
        for (int s = 0; s < 2; s++) begin
            take[s] = vin[s] && ((!m_has[s] && m_owner != s) || (resp && m_owner == s));
            if (vin[s] && !take[s]) n_err = 1;
            if (take[s]) begin
                n_has[s]  = 1;
                n_pend[s] = inreq[s];
            end
            want[s] = m_has[s] || take[s];
        end
        if (resp) n_owner = -1;
        go_d = want[1] && (!want[0] || PM == 1 || !m_lastd);
        if ((m_owner < 0 || resp) && (want[0] || want[1])) begin
            n_owner     = go_d ? 1 : 0;
            n_issue     = 1;
            n_lastd     = go_d;
            n_out       = n_pend[go_d];
            n_has[go_d] = 0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  <= '{default: '0};
            m_has   <= '{0, 0};
            m_owner <= -1;
            m_issue <= 0;
            m_out   <= '0;
            m_lastd <= 0;
            m_err   <= 0;
        end else begin
            m_pend  <= n_pend;
            m_has   <= n_has;
            m_owner <= n_owner;
            m_issue <= n_issue;
            m_out   <= n_out;
            m_lastd <= n_lastd;
            m_err   <= n_err;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %s, required %s", nm, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_issue});
        chk("mem_instr", {31'd0, mem_instr}, {31'd0, m_out.instr});
        chk("mem_addr", mem_addr, m_out.addr);
        chk("mem_wdata", mem_wdata, m_out.wdata);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_out.wstrb});
        chk("grant_d", {31'd0, grant_d}, {31'd0, m_owner == 1});
        chk("protocol_error", {31'd0, protocol_error}, {31'd0, m_err});
        chk("i_ready", {31'd0, i_ready}, {31'd0, m_owner == 0 && mem_ready && !m_issue});
        chk("d_ready", {31'd0, d_ready}, {31'd0, m_owner == 1 && mem_ready && !m_issue});
        if (i_ready) chk("i_rdata", i_rdata, mem_rdata);
        if (d_ready) chk("d_rdata", d_rdata, mem_rdata);
        if (mem_valid) mv_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic fair(input bit p, input string exp);
        string       got;
        int          ni, nd, ii, di;
        bit          prev, mv, gd;
        logic [68:0] o;
        logic [1:0]  r;
        logic [31:0] rd;
        got = "";
        ni = 1; nd = 1; ii = 0; di = 0; prev = 0;
        i_addr = 32'h1000; d_addr = 32'h2000;
        i_instr = 0; d_instr = 0; i_wdata = 0; d_wdata = 0; i_wstrb = 0; d_wstrb = 0;
        if (p) begin p_iv = 1; p_dv = 1; end else begin i_valid = 1; d_valid = 1; end
        for (int c = 0; c < 80 && got.len() < 8; c++) begin
            tick();
            i_valid = 0; d_valid = 0; mem_ready = 0; p_iv = 0; p_dv = 0; p_mr = 0;
            mv = p ? p_mem_valid : mem_valid;
            gd = p ? p_grant_d : grant_d;
            if (mv) begin
                got = gd ? {got, "D"} : {got, "I"};
                o = p ? {p_mem_instr, p_mem_addr, p_mem_wdata, p_mem_wstrb}
                      : {mem_instr, mem_addr, mem_wdata, mem_wstrb};
                chk("fair_addr", o[67:36], gd ? 32'h2000 + di : 32'h1000 + ii);
                chk("fair_wdata", o[35:4], 0);
                chk("fair_instr_wstrb", {27'd0, o[68], o[3:0]}, 0);
                if (gd) di++; else ii++;
            end
            if (prev) begin
                if (p) p_mr = 1; else mem_ready = 1;
                mem_rdata = 32'hC0DE0000 + c;
                if (gd && nd < 4) begin
                    d_addr = 32'h2000 + nd; nd++;
                    if (p) p_dv = 1; else d_valid = 1;
                end
                if (!gd && ni < 4) begin
                    i_addr = 32'h1000 + ni; ni++;
                    if (p) p_iv = 1; else i_valid = 1;
                end
                look();
                r  = p ? {p_i_ready, p_d_ready} : {i_ready, d_ready};
                rd = p ? (gd ? p_d_rdata : p_i_rdata) : (gd ? d_rdata : i_rdata);
                chk("fair_ready", {30'd0, r}, gd ? 32'd1 : 32'd2);
                chk("fair_rdata", rd, mem_rdata);
            end
            prev = mv;
        end
        chk_s(p ? "order_fixed" : "order_rr", got, exp);
        tick();
        if (p) p_mr = 1; else mem_ready = 1;
        tick();
        mem_ready = 0; p_mr = 0;
        tick();
    endtask

    initial begin
        int start, cnt;
        repeat (3) tick();
        look();
        chk("rst_mem_valid", {31'd0, mem_valid}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_grant_d", {31'd0, grant_d}, 0);
        chk("rst_protocol_error", {31'd0, protocol_error}, 0);
        rst = 0;
        tick();

        // single instruction read
        i_valid = 1; i_instr = 1; i_addr = 32'h100; i_wstrb = 0;
        tick();
        i_valid = 0; i_instr = 0;
        look();
        chk("rd_mem_valid", {31'd0, mem_valid}, 1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        tick();
        tick();
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        look();
        chk("rd_i_ready", {31'd0, i_ready}, 1);
        chk("rd_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("rd_d_ready", {31'd0, d_ready}, 0);
        tick();
        mem_ready = 0;

        // tie straight out of reset: data side first, then instruction
        rst = 1;
        tick();
        rst = 0;
        tick();
        i_valid = 1; d_valid = 1; i_addr = 32'h300; d_addr = 32'h200;
        tick();
        i_valid = 0; d_valid = 0;
        look();
        chk("tie_first_addr", mem_addr, 32'h200);
        chk("tie_first_grant_d", {31'd0, grant_d}, 1);
        tick();
        mem_ready = 1;
        look();
        chk("tie_d_ready", {31'd0, d_ready}, 1);
        tick();
        mem_ready = 0;
        look();
        chk("tie_second_valid", {31'd0, mem_valid}, 1);
        chk("tie_second_addr", mem_addr, 32'h300);
        chk("tie_second_grant_d", {31'd0, grant_d}, 0);
        tick();
        mem_ready = 1;
        look();
        chk("tie_i_ready", {31'd0, i_ready}, 1);
        tick();
        mem_ready = 0;

        // data write, response strobe exactly once even with a stray idle mem_ready
        d_valid = 1; d_addr = 32'h40; d_wstrb = 4'b0011; d_wdata = 32'h0000ABCD;
        tick();
        d_valid = 0;
        look();
        chk("wr_wstrb", {28'd0, mem_wstrb}, 32'h3);
        chk("wr_wdata", mem_wdata, 32'h0000ABCD);
        cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            mem_ready = (c == 3 || c == 4);
            look();
            cnt += int'(d_ready);
        end
        mem_ready = 0;
        d_wstrb = 0; d_wdata = 0;
        chk("wr_d_ready_pulses", cnt, 1);
        tick();

        // dropped request while the instruction slot is occupied
        start = mv_cnt;
        d_valid = 1; d_addr = 32'h600;
        tick();
        d_valid = 0; i_valid = 1; i_addr = 32'h700;
        tick();
        i_addr = 32'h704;
        tick();
        i_valid = 0;
        look();
        chk("perr_set", {31'd0, protocol_error}, 1);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        look();
        chk("perr_next_addr", mem_addr, 32'h700);
        tick();
        tick();
        mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();
        chk("perr_issue_count", mv_cnt - start, 2);
        chk("perr_sticky", {31'd0, protocol_error}, 1);

        // reset while a data transaction is outstanding
        d_valid = 1; d_addr = 32'h800;
        tick();
        d_valid = 0;
        tick();
        rst = 1;
        look();
        chk("mid_rst_grant_d", {31'd0, grant_d}, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_perr", {31'd0, protocol_error}, 0);
        chk("mid_rst_mem_valid", {31'd0, mem_valid}, 0);
        tick();
        rst = 0;
        tick();
        mem_ready = 1;
        look();
        chk("post_rst_d_ready", {31'd0, d_ready}, 0);
        chk("post_rst_i_ready", {31'd0, i_ready}, 0);
        tick();
        mem_ready = 0; i_valid = 1; i_addr = 32'h900;
        tick();
        i_valid = 0;
        look();
        chk("post_rst_valid", {31'd0, mem_valid}, 1);
        chk("post_rst_addr", mem_addr, 32'h900);
        tick();
        mem_ready = 1;
        look();
        chk("post_rst_i_ready2", {31'd0, i_ready}, 1);
        tick();
        mem_ready = 0;
        tick();

        // continuous traffic from both sides
        fair(0, "DIDIDIDI");
        fair(1, "DDDDIIII");
        chk("fixed_perr", {31'd0, p_protocol_error}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
